pcap_replay_sequencer: RTL and testbench

PCAP_REPLAY_SEQUENCER -- requirements
Module: pcap_replay_sequencer

---
 rtl/pcap_replay_sequencer.sv | 145 ++++++++++++++
 tb/tb_pcap_replay_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pcap_replay_sequencer.sv
// pcap_replay_sequencer
//   Replays a stored packet trace out of QDR memory. It walks word addresses
//   0..mem_addr_high in ADDR_STEP bursts for replay_count passes. It caps the
//   number of unreturned reads at MAX_OUTSTANDING and stops issuing while the
//   output FIFO is almost full.
//
// Ports
//   axi_aclk, axi_aresetn   clock, async active-low reset
//   sw_rst                  sync software abort (same effect as reset)
//   start_replay            level; its rising edge starts a replay from IDLE
//   mem_addr_high           last valid trace address (latched at start)
//   replay_count            passes to play (latched at start)
//   rd_req/rd_addr/rd_ready read request handshake (held until accepted)
//   rd_data_valid           one burst returned
//   fifo_almost_full        output buffer backpressure
//   busy, done, pass_count  status
//
// Configuration macro
//   PCAP_REPLAY_INFINITE_EN  defined: replay_count==0 loops until sw_rst.
//                            undefined: replay_count==0 goes straight to DONE.
module pcap_replay_sequencer #(
  parameter int QDR_ADDR_WIDTH     = 19,
  parameter int REPLAY_COUNT_WIDTH = 32,
  parameter int MAX_OUTSTANDING    = 16,
  parameter int ADDR_STEP          = 2
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          sw_rst,
  input  logic                          start_replay,
  input  logic [QDR_ADDR_WIDTH-1:0]     mem_addr_high,
  input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
  output logic                          rd_req,
  output logic [QDR_ADDR_WIDTH-1:0]     rd_addr,
  input  logic                          rd_ready,
  input  logic                          rd_data_valid,
  input  logic                          fifo_almost_full,
  output logic                          busy,
  output logic                          done,
  output logic [REPLAY_COUNT_WIDTH-1:0] pass_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]             MAX_W  = OW'(MAX_OUTSTANDING);
  localparam logic [QDR_ADDR_WIDTH:0]   STEP_W = (QDR_ADDR_WIDTH+1)'(ADDR_STEP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                    state;
  logic                          start_q;
  logic [QDR_ADDR_WIDTH-1:0]     hi_q;
  logic [REPLAY_COUNT_WIDTH-1:0] cnt_q;
  logic [OW-1:0]                 outstanding, out_nxt;

  logic                          start_edge, accept, ret, wrap, last_pass;
  logic                          finish, can_issue, zero_count;
  logic [QDR_ADDR_WIDTH:0]       addr_sum;
  logic [REPLAY_COUNT_WIDTH-1:0] pass_inc;

  always_comb begin
    start_edge = start_replay & ~start_q;
    accept     = rd_req & rd_ready;
    // A return with nothing outstanding is spurious and dropped.
    ret        = rd_data_valid & (outstanding != '0);
    out_nxt    = outstanding;
    if (accept && !ret)      out_nxt = outstanding + 1'b1;
    else if (!accept && ret) out_nxt = outstanding - 1'b1;
    // One bit wider so a high address near the top cannot overflow the test.
    addr_sum   = {1'b0, rd_addr} + STEP_W;
    wrap       = addr_sum > {1'b0, hi_q};
    pass_inc   = pass_count + 1'b1;
`ifdef PCAP_REPLAY_INFINITE_EN
    last_pass  = (cnt_q != '0) && (pass_inc == cnt_q);
    zero_count = 1'b0;
`else
    last_pass  = (pass_inc == cnt_q);
    zero_count = (replay_count == '0);
`endif
    finish     = accept & wrap & last_pass;
    // Judged on the count after this cycle's accept/return, because rd_req
    // is registered and takes effect next cycle.
    can_issue  = (out_nxt < MAX_W) & ~fifo_almost_full;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      pass_count  <= '0;
      outstanding <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
    end else if (sw_rst) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      pass_count  <= '0;
      outstanding <= '0;
    end else begin
      start_q     <= start_replay;
      outstanding <= out_nxt;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            hi_q       <= mem_addr_high;
            cnt_q      <= replay_count;
            rd_addr    <= '0;
            pass_count <= '0;
            state      <= zero_count ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (wrap) begin
              rd_addr    <= '0;
              pass_count <= pass_inc;
            end else begin
              rd_addr    <= addr_sum[QDR_ADDR_WIDTH-1:0];
            end
          end
          if (finish) begin
            rd_req <= 1'b0;
            state  <= S_DRAIN;
          end else if (!rd_req || accept) begin
            // A pending request is never withdrawn; only re-decide when idle
            // or when the current one has just gone.
            rd_req <= can_issue;
          end
        end
        S_DRAIN: if (outstanding == '0) state <= S_DONE;
        default: if (!start_replay)     state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_ISSUE) || (state == S_DRAIN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_pcap_replay_sequencer.sv
// Randomized bench for pcap_replay_sequencer. A reference model derives the
// k-th accepted address and the pass count by arithmetic on the trace length.
// It tracks outstanding reads with a queue of return times.
module tb_pcap_replay_sequencer;
  localparam int AW = 8, RW = 8, MAXO = 4, STEP = 2;

  logic          clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0, start = 1'b0;
  logic          rd_ready = 1'b0, dv = 1'b0, af = 1'b0;
  logic [AW-1:0] hi_in = '0;
  logic [RW-1:0] cnt_in = '0;
  logic          rd_req, busy, done;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] pass_count;

  pcap_replay_sequencer #(
    .QDR_ADDR_WIDTH(AW), .REPLAY_COUNT_WIDTH(RW),
    .MAX_OUTSTANDING(MAXO), .ADDR_STEP(STEP)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .sw_rst(sw_rst), .start_replay(start),
    .mem_addr_high(hi_in), .replay_count(cnt_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(dv), .fifo_almost_full(af),
    .busy(busy), .done(done), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, m_n = 1, k = 0, m_out = 0;
  int rdy_pct = 100, af_pct = 0, lat_min = 3, lat_max = 3;
  bit ret_en = 1'b1;
  int due_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe the handshake before the edge, check after it, then
  // drive the next inputs.
  task automatic tick();
    bit acc, d, s, af_b, req_b;
    logic [AW-1:0] a_b;
    acc = rd_req && rd_ready; d = dv; s = sw_rst; af_b = af; req_b = rd_req; a_b = rd_addr;
    @(posedge clk); #1; cyc++;
    if (s) begin
      due_q.delete(); m_out = 0;
    end else begin
      if (d && m_out > 0) m_out--;
      if (acc) begin
        chk("rd_addr", 64'(a_b), 64'((k % m_n) * STEP));
        k++; m_out++;
        chk("outstanding_cap", 64'(m_out <= MAXO), 64'd1);
        chk("pass_count", 64'(pass_count), 64'((k / m_n) % 256));
        due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (req_b && !acc) begin
        chk("hold_req", 64'(rd_req), 64'd1);
        chk("hold_addr", 64'(rd_addr), 64'(a_b));
      end
      if (rd_req && (!req_b || acc)) begin
        chk("new_req_af", 64'(af_b), 64'd0);
        chk("new_req_cap", 64'(m_out < MAXO), 64'd1);
      end
    end
    dv = 1'b0;
    if (ret_en && due_q.size() > 0 && due_q[0] <= cyc) begin
      dv = 1'b1; void'(due_q.pop_front());
    end
    rd_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    af       = (int'($urandom_range(99, 0)) < af_pct);
  endtask

  task automatic begin_replay(input int hi, input int cnt);
    m_n = hi / STEP + 1; k = 0;
    hi_in = AW'(hi); cnt_in = RW'(cnt); start = 1'b1;
    tick();
    // Latched values must be immune to later register writes.
    hi_in = AW'($urandom()); cnt_in = RW'($urandom());
    tick();
    start = 1'b0;
  endtask

  task automatic finish_replay(input int cnt);
    int n = 0;
    ret_en = 1'b1;
    while (!done && n < 4000) begin tick(); n++; end
    chk("done_reached", 64'(done), 64'd1);
    chk("total_reqs", 64'(k), 64'(cnt * m_n));
    chk("final_pass", 64'(pass_count), 64'(cnt));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("drained", 64'(m_out), 64'd0);
    tick();
    chk("back_idle", 64'(done), 64'd0);
  endtask

  task automatic run_replay(input int hi, input int cnt, input int rp, input int ap,
                            input int lmin, input int lmax);
    rdy_pct = rp; af_pct = ap; lat_min = lmin; lat_max = lmax; ret_en = 1'b1;
    begin_replay(hi, cnt);
    finish_replay(cnt);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass_count), 64'd0);
    #10 rstn = 1'b1;
    tick(); tick();
    chk("idle_no_start", 64'(busy), 64'd0);

    // Basic trace: 0,2,4,6 twice, fixed 3-cycle return latency.
    run_replay(7, 2, 100, 0, 3, 3);

    // Withheld returns: exactly MAX_OUTSTANDING requests, then silence.
    rdy_pct = 100; af_pct = 0; ret_en = 1'b0;
    begin_replay(30, 1);
    repeat (20) tick();
    chk("stall_count", 64'(k), 64'(MAXO));
    chk("stall_req", 64'(rd_req), 64'd0);
    finish_replay(1);

    // Not-ready for several cycles, then backpressure blocks new requests.
    rdy_pct = 0; af_pct = 0; lat_min = 2; lat_max = 4;
    begin_replay(15, 1);
    repeat (5) tick();
    chk("notready_pending", 64'(rd_req), 64'd1);
    chk("notready_count", 64'(k), 64'd0);
    af_pct = 100; rdy_pct = 100;
    repeat (3) tick();
    n = k;
    repeat (6) tick();
    chk("af_no_new", 64'(k), 64'(n));
    af_pct = 0;
    finish_replay(1);

    // Software abort while the third request is pending.
    rdy_pct = 100; af_pct = 0; lat_min = 3; lat_max = 3; ret_en = 1'b1;
    begin_replay(15, 3);
    n = 0;
    while (!(k == 2 && rd_req) && n < 200) begin tick(); n++; end
    chk("third_req_seen", 64'(k == 2 && rd_req), 64'd1);
    sw_rst = 1'b1; tick(); sw_rst = 1'b0;
    chk("swrst_rd_req", 64'(rd_req), 64'd0);
    chk("swrst_rd_addr", 64'(rd_addr), 64'd0);
    chk("swrst_busy", 64'(busy), 64'd0);
    chk("swrst_done", 64'(done), 64'd0);
    chk("swrst_pass", 64'(pass_count), 64'd0);
    repeat (4) tick();
    chk("swrst_stays_idle", 64'(busy), 64'd0);
    run_replay(15, 3, 100, 0, 3, 3);

    // Zero replay count.
`ifdef PCAP_REPLAY_INFINITE_EN
    rdy_pct = 80; af_pct = 10; lat_min = 1; lat_max = 5;
    begin_replay(5, 0);
    n = 0;
    while (k < 3 * m_n + 1 && n < 2000) begin tick(); n++; end
    chk("inf_progress", 64'(k >= 3 * m_n + 1), 64'd1);
    chk("inf_busy", 64'(busy), 64'd1);
    sw_rst = 1'b1; tick(); sw_rst = 1'b0;
    chk("inf_stop", 64'(busy), 64'd0);
`else
    hi_in = 8'd5; cnt_in = '0; start = 1'b1;
    tick();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_no_req", 64'(rd_req), 64'd0);
    start = 1'b0;
    tick();
    chk("zero_idle", 64'(done), 64'd0);
    chk("zero_no_req2", 64'(rd_req), 64'd0);
`endif
    repeat (3) tick();

    // Spurious return while idle must not disturb the next replay.
    dv = 1'b1; tick();

    for (int i = 0; i < 8; i++)
      run_replay(int'($urandom_range(20, 0)), int'($urandom_range(3, 1)),
                 int'($urandom_range(100, 30)), int'($urandom_range(50, 0)), 1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
